// File: rtl/piso_tx_sched.sv
// piso_tx_sched: round-robin transmit scheduler driving the shared PISO shifter
// (load strobe, data bus, divided shift strobe, frame-done pulse).
module piso_tx_sched #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] baud_div,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             piso_on,
    output logic             piso_enable,
    output logic [WIDTH-1:0] piso_data,
    output logic             grant_id,
    output logic             busy,
    output logic             frame_done
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t           state;
    logic             last_grant;
    logic [DIV_W-1:0] baud_q;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic             idle_en;

    assign idle_en    = (state == IDLE) & enable & ~reset;
    assign req0_ready = idle_en & req0_valid & (~req1_valid | last_grant);
    assign req1_ready = idle_en & req1_valid & (~req0_valid | ~last_grant);
    assign div_nxt    = div_cnt + DIV_W'(1);

    // piso_enable is registered, so it is raised one cycle early when the
    // divider is about to reach the latched period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            baud_q      <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            piso_on     <= 1'b0;
            piso_enable <= 1'b0;
            piso_data   <= '0;
            grant_id    <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready | req1_ready) begin
                        piso_data  <= req1_ready ? req1_data : req0_data;
                        baud_q     <= baud_div;
                        grant_id   <= req1_ready;
                        last_grant <= req1_ready;
                        busy       <= 1'b1;
                        piso_on    <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    piso_on     <= 1'b0;
                    div_cnt     <= '0;
                    bit_cnt     <= '0;
                    piso_enable <= (baud_q == '0);
                    state       <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == baud_q) begin
                        div_cnt <= '0;
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == CNT_W'(WIDTH - 1)) begin
                            piso_enable <= 1'b0;
                            frame_done  <= 1'b1;
                            state       <= DONE;
                        end else begin
                            piso_enable <= (baud_q == '0);
                        end
                    end else begin
                        div_cnt     <= div_nxt;
                        piso_enable <= (div_nxt == baud_q);
                    end
                end
                DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
